// File: rtl/en_tick_ctrl.sv
// en_tick_ctrl: debounced start/stop buttons driving a RUN/PAUSE/IDLE FSM
// that emits a one-cycle en tick every div_q+1 cycles while running.

// en_tick_deb: 2-flop synchroniser, stability-count debouncer and
// rising-edge press detector for one raw button.
module en_tick_deb #(
  parameter int DEB_LEN = 4
) (
  input  logic Clk,
  input  logic resetn,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEB_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEB_LEN - 1);

  logic          s1_q, s2_q;
  logic          deb_q, deb_d;
  logic          press_q, press_d;
  logic [CW-1:0] stab_q, stab_d;

  // Synchronise the raw level before anything else looks at it.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
    end
  end

  // Count consecutive mismatching cycles; the DEB_LEN-th one flips the
  // debounced level, and only a 0->1 flip produces a press pulse.
  always_comb begin
    deb_d   = deb_q;
    stab_d  = '0;
    press_d = 1'b0;
    if (s2_q != deb_q) begin
      if (stab_q == LAST_CNT) begin
        deb_d   = s2_q;
        stab_d  = '0;
        press_d = s2_q;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
  end

  // Debouncer state registers.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      deb_q   <= 1'b0;
      stab_q  <= '0;
      press_q <= 1'b0;
    end else begin
      deb_q   <= deb_d;
      stab_q  <= stab_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

module en_tick_ctrl #(
  parameter int DEB_LEN = 4,
  parameter int DIV_W   = 8
) (
  input  logic             Clk,
  input  logic             resetn,
  input  logic             start_btn,
  input  logic             stop_btn,
  input  logic [DIV_W-1:0] div,
  output logic             en,
  output logic             running,
  output logic [1:0]       state
);

  // Handshake: none. start/stop are raw levels; en is a free-running
  // one-cycle strobe with no back-pressure from the downstream counter.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  logic             start_ev, stop_ev;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             en_q, en_d;
  logic             running_q, running_d;

  en_tick_deb #(.DEB_LEN(DEB_LEN)) u_start_deb (
    .Clk    (Clk),
    .resetn (resetn),
    .btn    (start_btn),
    .press  (start_ev)
  );

  en_tick_deb #(.DEB_LEN(DEB_LEN)) u_stop_deb (
    .Clk    (Clk),
    .resetn (resetn),
    .btn    (stop_btn),
    .press  (stop_ev)
  );

  // Next state, prescaler and tick; stop is tested first so it wins ties.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    en_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stop_ev && start_ev) begin
          state_d = ST_RUN;
          div_d   = div;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (stop_ev) begin
          // Leaving RUN: hold cnt and suppress any tick this cycle.
          state_d = ST_PAUSE;
        end else if (cnt_q == div_q) begin
          cnt_d = '0;
          en_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (stop_ev) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (start_ev) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    running_d = (state_d == ST_RUN);
  end

  // FSM and datapath registers.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      en_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      en_q      <= en_d;
      running_q <= running_d;
    end
  end

  assign en      = en_q;
  assign running = running_q;
  assign state   = state_q;

endmodule

// File: tb/tb_en_tick_ctrl.sv
// tb_en_tick_ctrl: scenario tasks push expected {state,running,en} per cycle
// into exp_q, then drive stimulus and pop/compare at every falling edge.
module tb_en_tick_ctrl;

  logic       Clk;
  logic       resetn;
  logic       start_btn;
  logic       stop_btn;
  logic [7:0] div;
  logic       en;
  logic       running;
  logic [1:0] state;

  logic [3:0] exp_q[$];
  int         checks;
  int         errors;

  en_tick_ctrl #(.DEB_LEN(4), .DIV_W(8)) dut (
    .Clk       (Clk),
    .resetn    (resetn),
    .start_btn (start_btn),
    .stop_btn  (stop_btn),
    .div       (div),
    .en        (en),
    .running   (running),
    .state     (state)
  );

  // Clock and reset block.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic do_reset(input logic hold_start);
    resetn    = 1'b0;
    stop_btn  = 1'b0;
    start_btn = hold_start;
    div       = 8'd0;
    repeat (3) @(negedge Clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] got, exp;
    resetn = 1'b0; start_btn = 1'b0; stop_btn = 1'b0; div = 8'd0;
    #1;
    exp_q.push_back(4'b0000);
    got = {state, running, en};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_async got %b exp %b", got, exp);
    end
    repeat (2) @(negedge Clk);
    resetn = 1'b1;
    for (int k = 1; k <= 5; k++) exp_q.push_back(4'b0000);
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      got = {state, running, en};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_idle k=%0d got %b exp %b", k, got, exp);
      end
    end
  endtask

  task automatic test_start_run();
    logic [3:0] got, exp;
    do_reset(1'b0);
    div = 8'd3; start_btn = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      logic [1:0] st;
      logic       en_e;
      st   = (k >= 7) ? 2'b01 : 2'b00;
      en_e = (k >= 11) && ((k - 11) % 4 == 0);
      exp_q.push_back({st, (st == 2'b01), en_e});
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clk);
      got = {state, running, en};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL start_run k=%0d got %b exp %b", k, got, exp);
      end
      if (k == 10) start_btn = 1'b0;
    end
  endtask

  task automatic test_glitch();
    logic [3:0] got, exp;
    do_reset(1'b0);
    div = 8'd1; start_btn = 1'b1;
    for (int k = 1; k <= 20; k++) exp_q.push_back(4'b0000);
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      got = {state, running, en};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL glitch k=%0d got %b exp %b", k, got, exp);
      end
      if (k == 3) start_btn = 1'b0;
    end
  endtask

  task automatic test_held_reset();
    logic [3:0] got, exp;
    do_reset(1'b1);
    div = 8'd1;
    for (int k = 1; k <= 14; k++) begin
      logic [1:0] st;
      logic       en_e;
      st   = (k >= 7) ? 2'b01 : 2'b00;
      en_e = (k >= 9) && ((k - 9) % 2 == 0);
      exp_q.push_back({st, (st == 2'b01), en_e});
    end
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clk);
      got = {state, running, en};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL held_reset k=%0d got %b exp %b", k, got, exp);
      end
      if (k == 10) start_btn = 1'b0;
    end
  endtask

  task automatic test_pause_resume();
    logic [3:0] got, exp;
    do_reset(1'b0);
    div = 8'd5; start_btn = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      logic [1:0] st;
      logic       en_e;
      if (k < 7)       st = 2'b00;
      else if (k < 10) st = 2'b01;
      else if (k < 36) st = 2'b10;
      else             st = 2'b01;
      en_e = (k >= 40) && ((k - 40) % 6 == 0);
      exp_q.push_back({st, (st == 2'b01), en_e});
    end
    for (int k = 1; k <= 55; k++) begin
      @(negedge Clk);
      got = {state, running, en};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pause_resume k=%0d got %b exp %b", k, got, exp);
      end
      if (k == 3)  stop_btn = 1'b1;
      if (k == 8)  begin start_btn = 1'b0; stop_btn = 1'b0; end
      if (k == 29) start_btn = 1'b1;
      if (k == 33) start_btn = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp;
    do_reset(1'b0);
    div = 8'd2; start_btn = 1'b1;
    for (int k = 1; k <= 56; k++) begin
      logic [1:0] st;
      logic       en_e;
      if (k < 7)       st = 2'b00;
      else if (k < 23) st = 2'b01;
      else if (k < 35) st = 2'b10;
      else if (k < 47) st = 2'b00;
      else             st = 2'b01;
      en_e = ((k >= 10) && (k <= 22) && ((k - 10) % 3 == 0)) ||
             ((k >= 50) && ((k - 50) % 3 == 0));
      exp_q.push_back({st, (st == 2'b01), en_e});
    end
    for (int k = 1; k <= 56; k++) begin
      @(negedge Clk);
      got = {state, running, en};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL simultaneous k=%0d got %b exp %b", k, got, exp);
      end
      if (k == 8)  start_btn = 1'b0;
      if (k == 16) begin start_btn = 1'b1; stop_btn = 1'b1; end
      if (k == 20) begin start_btn = 1'b0; stop_btn = 1'b0; end
      if (k == 28) begin start_btn = 1'b1; stop_btn = 1'b1; end
      if (k == 32) begin start_btn = 1'b0; stop_btn = 1'b0; end
      if (k == 40) start_btn = 1'b1;
      if (k == 44) start_btn = 1'b0;
    end
  endtask

  task automatic test_div0_change();
    logic [3:0] got, exp;
    do_reset(1'b0);
    div = 8'd0; start_btn = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      logic [1:0] st;
      st = (k >= 7) ? 2'b01 : 2'b00;
      exp_q.push_back({st, (st == 2'b01), (k >= 8)});
    end
    for (int k = 1; k <= 25; k++) begin
      @(negedge Clk);
      got = {state, running, en};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL div0_change k=%0d got %b exp %b", k, got, exp);
      end
      if (k == 8)  start_btn = 1'b0;
      if (k == 12) div = 8'($urandom_range(1, 200));
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] got, exp;
    exp_q.push_back(4'b0111);
    exp_q.push_back(4'b0000);
    for (int k = 1; k <= 6; k++) exp_q.push_back(4'b0000);
    @(negedge Clk);
    got = {state, running, en};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL async_pre got %b exp %b", got, exp);
    end
    #2 resetn = 1'b0;
    #1;
    got = {state, running, en};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL async_clear got %b exp %b", got, exp);
    end
    @(negedge Clk);
    resetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      got = {state, running, en};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL async_after k=%0d got %b exp %b", k, got, exp);
      end
    end
  endtask

  // Test sequence and final report.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_start_run();
    test_glitch();
    test_held_reset();
    test_pause_resume();
    test_back_to_back();
    test_div0_change();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/en_tick_ctrl.md
EN_TICK_CTRL -- requirements
Module: en_tick_ctrl

Interface
REQ-001 Parameter DEB_LEN, default 4, number of consecutive stable synchronised cycles required to accept a button level (range 2..255).
REQ-002 Parameter DIV_W, default 8, width of the prescaler divide value and counter.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 start_btn  input  1  raw asynchronous start/resume button, active-high.
REQ-006 stop_btn  input  1  raw asynchronous pause/clear button, active-high.
REQ-007 div  input  DIV_W  divide value; sampled only on IDLE->RUN.
REQ-008 en  output  1  registered one-cycle tick feeding the downstream ring counter's en.
REQ-009 running  output  1  registered; 1 exactly while state is RUN.
REQ-010 state  output  2  registered FSM encoding: IDLE=00, RUN=01, PAUSE=10; 11 unused.

Function
REQ-011 Each button SHALL pass through a 2-flop synchroniser before any other logic.
REQ-012 Per button, a stability counter SHALL count consecutive cycles where the synchronised level differs from the debounced level; it clears to 0 when they match.
REQ-013 When the stability counter reaches DEB_LEN, the debounced level SHALL take the synchronised level and the counter clears.
REQ-014 A press event SHALL be a one-cycle pulse on a debounced 0->1 transition; 1->0 transitions generate no event.
REQ-015 Press event latency SHALL be exactly 2+DEB_LEN rising edges from the first edge sampling the raw input high; the FSM reacts on the next edge.
REQ-016 Glitches shorter than DEB_LEN synchronised cycles SHALL generate no event.
REQ-017 IDLE + start event -> RUN; div latched into div_q; prescaler cnt cleared to 0.
REQ-018 RUN + stop event -> PAUSE; cnt and div_q held.
REQ-019 PAUSE + start event -> RUN; cnt resumes from held value; div not resampled.
REQ-020 PAUSE + stop event -> IDLE; cnt cleared.
REQ-021 IDLE + stop event, RUN + start event: no change.
REQ-022 Start and stop events in the same cycle: stop SHALL win (RUN->PAUSE, PAUSE->IDLE, IDLE stays).
REQ-023 In RUN, cnt SHALL increment each cycle; when cnt==div_q it wraps to 0 and en is set high for the following cycle only.
REQ-024 en period in steady RUN SHALL be div_q+1 cycles; div_q=0 gives en high every cycle.
REQ-025 en SHALL be 0 in IDLE and PAUSE; the cycle leaving RUN produces no new en pulse.
REQ-026 First en after IDLE->RUN SHALL be high div_q+1 cycles after the first RUN cycle.
REQ-027 cnt width DIV_W; no overflow possible since cnt never exceeds div_q.

Reset
REQ-028 On resetn=0, immediately and regardless of Clk: state=IDLE, en=0, running=0, cnt=0, div_q=0, synchroniser flops, debounced levels and stability counters all 0.
REQ-029 A button held high through reset release SHALL generate a press event after debounce (debounced level restarts at 0).
REQ-030 Reset asserted mid-RUN SHALL abort any pending en pulse; no en on the cycle after release.

Verification
REQ-031 div=3, start pulse held 10 cycles -> state RUN after 2+4+1 edges; en high 1 of every 4 cycles; first en 4 cycles into RUN.
REQ-032 start_btn glitch of 3 cycles (DEB_LEN=4) -> state stays IDLE, en stays 0.
REQ-033 RUN div=5, stop at cnt=2, hold 20 cycles, start -> no en while PAUSE; first en after resume arrives 4 cycles into RUN.
REQ-034 Start and stop pressed simultaneously from RUN -> PAUSE; again simultaneously -> IDLE, cnt=0.
REQ-035 div=0 -> en continuously high during RUN; changing div while RUN has no effect until next IDLE->RUN.
REQ-036 resetn driven low between clock edges mid-RUN -> en, running, state clear without waiting for Clk.
